rvx_bus_arbiter: RTL and testbench

- Multi-manager, multi-device bus interconnect: NUM_MANAGERS request ports are arbitrated round-robin onto one shared path to NUM_DEVICES memory-mapped devices.
- Adds registered request routing, per-transaction timeout and decode/timeout error reporting.
- Sits between the processor core plus DMA-style managers and the peripheral/memory devices of the RVX SoC.

---
 rtl/rvx_bus_pkg.sv | 21 ++
 rtl/rvx_bus_rr_arbiter.sv | 35 +++
 rtl/rvx_bus_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_rvx_bus_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvx_bus_pkg.sv
// Shared types and widths for the RVX shared-bus interconnect.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rvx_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } bus_state_t;

    // Index width that stays legal (>=1 bit) even for a single port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rvx_bus_rr_arbiter.sv
// Round-robin pick of one pending requester, searching upward from last_grant+1.
// Latency: purely combinational.
// Backpressure: none; caller decides when the grant is consumed.
module rvx_bus_rr_arbiter
    import rvx_bus_pkg::*;
#(
    parameter int NUM_MANAGERS = 2,
    localparam int IW = idx_width(NUM_MANAGERS)
) (
    input  logic [NUM_MANAGERS-1:0] pending,
    input  logic [IW-1:0]           last_grant,
    output logic [NUM_MANAGERS-1:0] grant,
    output logic [IW-1:0]           grant_index
);

    logic found;

    // Walk offsets 1..N from the last winner; the first pending candidate wins.
    always_comb begin
        grant       = '0;
        grant_index = '0;
        found       = 1'b0;
        for (int k = 1; k <= NUM_MANAGERS; k++) begin
            for (int i = 0; i < NUM_MANAGERS; i++) begin
                if (!found && pending[i] &&
                    (((int'(last_grant) + k) % NUM_MANAGERS) == i)) begin
                    found       = 1'b1;
                    grant[i]    = 1'b1;
                    grant_index = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/rvx_bus_arbiter.sv
// Shared bus: round-robin managers onto one path to address-decoded devices, with timeout.
// Latency: request in IDLE at T -> device request T+1; device response at T+1 -> manager response T+2; decode miss -> T+1.
// Backpressure: requests are held until the one-cycle response pulse; one transaction in flight at a time.
module rvx_bus_arbiter
    import rvx_bus_pkg::*;
#(
    parameter int NUM_MANAGERS   = 2,
    parameter int NUM_DEVICES    = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_MANAGERS*ADDR_W-1:0]   manager_rw_address,
    output logic [DATA_W-1:0]                manager_read_data,
    input  logic [NUM_MANAGERS-1:0]          manager_read_request,
    output logic [NUM_MANAGERS-1:0]          manager_read_response,
    input  logic [NUM_MANAGERS*DATA_W-1:0]   manager_write_data,
    input  logic [NUM_MANAGERS*STRB_W-1:0]   manager_write_strobe,
    input  logic [NUM_MANAGERS-1:0]          manager_write_request,
    output logic [NUM_MANAGERS-1:0]          manager_write_response,
    output logic [NUM_MANAGERS-1:0]          manager_access_error,
    output logic [ADDR_W-1:0]                device_rw_address,
    input  logic [NUM_DEVICES*DATA_W-1:0]    device_read_data,
    output logic [NUM_DEVICES-1:0]           device_read_request,
    input  logic [NUM_DEVICES-1:0]           device_read_response,
    output logic [DATA_W-1:0]                device_write_data,
    output logic [STRB_W-1:0]                device_write_strobe,
    output logic [NUM_DEVICES-1:0]           device_write_request,
    input  logic [NUM_DEVICES-1:0]           device_write_response,
    input  logic [NUM_DEVICES*ADDR_W-1:0]    device_start_address,
    input  logic [NUM_DEVICES*ADDR_W-1:0]    device_region_size
);

    localparam int MIW = idx_width(NUM_MANAGERS);
    localparam int DIW = idx_width(NUM_DEVICES);

    bus_state_t               state_q, state_d;
    logic [MIW-1:0]           last_grant_q, grant_q;
    logic                     is_read_q, error_q;
    logic [DIW-1:0]           dev_sel_q;
    logic [DATA_W-1:0]        rdata_q;
    logic [31:0]              timer_q;

    logic [NUM_MANAGERS-1:0]  pending, arb_grant;
    logic [MIW-1:0]           arb_index;
    logic [ADDR_W-1:0]        sel_addr;
    logic [DATA_W-1:0]        sel_wdata, sel_rdata;
    logic [STRB_W-1:0]        sel_strb;
    logic                     sel_read;
    logic [NUM_DEVICES-1:0]   dev_hit, dev_onehot;
    logic                     dec_hit, dev_done, dev_timeout;
    logic [DIW-1:0]           dec_index;

    assign pending = manager_read_request | manager_write_request;

    rvx_bus_rr_arbiter #(.NUM_MANAGERS(NUM_MANAGERS)) u_rr (
        .pending     (pending),
        .last_grant  (last_grant_q),
        .grant       (arb_grant),
        .grant_index (arb_index)
    );

    // Steer the winning manager's request fields; read takes precedence over write.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_strb  = '0;
        sel_read  = 1'b0;
        for (int i = 0; i < NUM_MANAGERS; i++) begin
            if (arb_grant[i]) begin
                sel_addr  = manager_rw_address[i*ADDR_W +: ADDR_W];
                sel_wdata = manager_write_data[i*DATA_W +: DATA_W];
                sel_strb  = manager_write_strobe[i*STRB_W +: STRB_W];
                sel_read  = manager_read_request[i];
            end
        end
    end

    // Regions are size-aligned, so masking off the offset bits must yield the base.
    for (genvar g = 0; g < NUM_DEVICES; g++) begin : g_dec
        assign dev_hit[g] = (sel_addr & ~(device_region_size[g*ADDR_W +: ADDR_W] - 32'd1))
                            == device_start_address[g*ADDR_W +: ADDR_W];
    end

    // Overlapping regions resolve to the lowest device index.
    always_comb begin
        dec_hit   = 1'b0;
        dec_index = '0;
        for (int i = NUM_DEVICES - 1; i >= 0; i--) begin
            if (dev_hit[i]) begin
                dec_hit   = 1'b1;
                dec_index = DIW'(i);
            end
        end
    end

    // Only the selected device's matching response (and read data) is listened to.
    always_comb begin
        dev_onehot = '0;
        dev_done   = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < NUM_DEVICES; i++) begin
            if (dev_sel_q == DIW'(i)) begin
                dev_onehot[i] = 1'b1;
                sel_rdata     = device_read_data[i*DATA_W +: DATA_W];
                dev_done      = is_read_q ? device_read_response[i] : device_write_response[i];
            end
        end
    end

    assign dev_timeout = (TIMEOUT_CYCLES != 0) && (timer_q == 32'(TIMEOUT_CYCLES - 1));

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: a same-cycle response beats a timeout because it is tested first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (|pending) state_d = dec_hit ? ST_ACCESS : ST_RESPOND;
            ST_ACCESS:  if (dev_done || dev_timeout) state_d = ST_RESPOND;
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Transaction latch, timer and completion status.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q        <= MIW'(NUM_MANAGERS - 1);
            grant_q             <= '0;
            is_read_q           <= 1'b0;
            dev_sel_q           <= '0;
            error_q             <= 1'b0;
            rdata_q             <= '0;
            timer_q             <= '0;
            device_rw_address   <= '0;
            device_write_data   <= '0;
            device_write_strobe <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (|pending) begin
                    grant_q             <= arb_index;
                    is_read_q           <= sel_read;
                    dev_sel_q           <= dec_index;
                    device_rw_address   <= sel_addr;
                    device_write_data   <= sel_wdata;
                    device_write_strobe <= sel_strb;
                    timer_q             <= '0;
                    error_q             <= !dec_hit;
                    rdata_q             <= '0;
                end
                ST_ACCESS: begin
                    timer_q <= timer_q + 32'd1;
                    if (dev_done) begin
                        error_q <= 1'b0;
                        rdata_q <= is_read_q ? sel_rdata : '0;
                    end else if (dev_timeout) begin
                        error_q <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                ST_RESPOND: begin
                    last_grant_q <= grant_q;
                    timer_q      <= '0;
                end
                default: ;
            endcase
        end
    end

    assign device_read_request  = (state_q == ST_ACCESS &&  is_read_q) ? dev_onehot : '0;
    assign device_write_request = (state_q == ST_ACCESS && !is_read_q) ? dev_onehot : '0;

    // Manager-side completion is visible only during RESPOND, and only to the granted port.
    always_comb begin
        manager_read_response  = '0;
        manager_write_response = '0;
        manager_access_error   = '0;
        manager_read_data      = '0;
        if (state_q == ST_RESPOND) begin
            manager_read_data = rdata_q;
            for (int i = 0; i < NUM_MANAGERS; i++) begin
                if (grant_q == MIW'(i)) begin
                    manager_read_response[i]  = is_read_q;
                    manager_write_response[i] = !is_read_q;
                    manager_access_error[i]   = error_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_rvx_bus_arbiter.sv
// Randomized scoreboard bench for rvx_bus_arbiter (2 managers, 2 devices, timeout 8).
// Latency: checks device request, response and timeout cycle relationships.
// Backpressure: managers hold requests until their response pulse.
module tb_rvx_bus_arbiter;

    localparam int NM  = 2;
    localparam int ND  = 2;
    localparam int TMO = 8;

    typedef struct {
        bit          err;
        bit          is_read;
        logic [31:0] data;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [NM*32-1:0] manager_rw_address, manager_write_data;
    logic [NM*4-1:0]  manager_write_strobe;
    logic [NM-1:0]    manager_read_request, manager_write_request;
    logic [NM-1:0]    manager_read_response, manager_write_response, manager_access_error;
    logic [31:0]      manager_read_data;
    logic [31:0]      device_rw_address, device_write_data;
    logic [3:0]       device_write_strobe;
    logic [ND*32-1:0] device_read_data, device_start_address, device_region_size;
    logic [ND-1:0]    device_read_request, device_read_response;
    logic [ND-1:0]    device_write_request, device_write_response;

    logic [31:0] m_addr[NM], m_wdata[NM];
    logic [3:0]  m_strb[NM];
    logic        m_rd_req[NM], m_wr_req[NM];
    logic [31:0] d_rdata[ND], d_start[ND], d_size[ND];
    logic        d_rresp[ND], d_wresp[ND];

    always_comb begin
        for (int i = 0; i < NM; i++) begin
            manager_rw_address[i*32 +: 32]  = m_addr[i];
            manager_write_data[i*32 +: 32]  = m_wdata[i];
            manager_write_strobe[i*4 +: 4]  = m_strb[i];
            manager_read_request[i]         = m_rd_req[i];
            manager_write_request[i]        = m_wr_req[i];
        end
        for (int i = 0; i < ND; i++) begin
            device_read_data[i*32 +: 32]     = d_rdata[i];
            device_start_address[i*32 +: 32] = d_start[i];
            device_region_size[i*32 +: 32]   = d_size[i];
            device_read_response[i]          = d_rresp[i];
            device_write_response[i]         = d_wresp[i];
        end
    end

    rvx_bus_arbiter #(.NUM_MANAGERS(NM), .NUM_DEVICES(ND), .TIMEOUT_CYCLES(TMO)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .manager_rw_address     (manager_rw_address),
        .manager_read_data      (manager_read_data),
        .manager_read_request   (manager_read_request),
        .manager_read_response  (manager_read_response),
        .manager_write_data     (manager_write_data),
        .manager_write_strobe   (manager_write_strobe),
        .manager_write_request  (manager_write_request),
        .manager_write_response (manager_write_response),
        .manager_access_error   (manager_access_error),
        .device_rw_address      (device_rw_address),
        .device_read_data       (device_read_data),
        .device_read_request    (device_read_request),
        .device_read_response   (device_read_response),
        .device_write_data      (device_write_data),
        .device_write_strobe    (device_write_strobe),
        .device_write_request   (device_write_request),
        .device_write_response  (device_write_response),
        .device_start_address   (device_start_address),
        .device_region_size     (device_region_size)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    exp_t exp_q0[$], exp_q1[$];
    int   grant_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference rules: region membership, deaf window, device data pattern, round-robin order.
    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < ND; i++)
            if ({1'b0, a} >= {1'b0, d_start[i]} && {1'b0, a} < {1'b0, d_start[i]} + {1'b0, d_size[i]})
                return i;
        return -1;
    endfunction

    function automatic bit is_deaf(input logic [31:0] a);
        return a[11:9] == 3'b111;
    endfunction

    function automatic logic [31:0] dev_val(input int d, input logic [31:0] a);
        return a ^ 32'hCAFE_0000 ^ (32'(d) * 32'h0101_0101);
    endfunction

    function automatic int rr_pick(input logic [NM-1:0] pend, input int last);
        for (int k = 1; k <= NM; k++)
            if (pend[(last + k) % NM]) return (last + k) % NM;
        return -1;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Device behaviour: random latency, deaf window never answers (then answers late), noise when unselected.
    task automatic run_dev(input int d);
        bit busy, deaf, was_read;
        int cnt, lat;
        busy = 0; deaf = 0; was_read = 0; cnt = 0; lat = 0;
        forever begin
            @(posedge clock); #2;
            d_rresp[d] = 1'b0;
            d_wresp[d] = 1'b0;
            if (reset) begin
                busy = 0;
            end else if (device_read_request[d] | device_write_request[d]) begin
                if (!busy) begin
                    busy     = 1;
                    cnt      = 0;
                    lat      = ($urandom_range(0, 7) == 0) ? TMO - 1 : $urandom_range(0, 3);
                    deaf     = is_deaf(device_rw_address);
                    was_read = device_read_request[d];
                end
                if (!deaf && cnt == lat) begin
                    if (was_read) d_rresp[d] = 1'b1; else d_wresp[d] = 1'b1;
                    d_rdata[d] = dev_val(d, device_rw_address);
                end
                cnt++;
            end else if (busy) begin
                busy = 0;
                if (deaf) begin
                    if (was_read) d_rresp[d] = 1'b1; else d_wresp[d] = 1'b1;
                    d_rdata[d] = 32'hDEAD_0000;
                end
            end else if ((device_read_request | device_write_request) != '0 && $urandom_range(0, 3) == 0) begin
                d_rresp[d] = 1'b1;
                d_wresp[d] = 1'b1;
                d_rdata[d] = $urandom;
            end
        end
    endtask

    // One manager issuing n random transactions; the expected result is queued at issue time.
    task automatic run_mgr(input int m, input int n);
        exp_t        e;
        logic [31:0] a;
        int          c, dev, dly;
        bit          got;
        for (int t = 0; t < n; t++) begin
            c = $urandom_range(0, 7);
            if (c <= 3)      a = 32'($urandom_range(0, 32'h1FFF)) & 32'hFFFF_FFFC;
            else if (c <= 5) a = 32'h0001_0000 + (32'($urandom_range(0, 32'hFFF)) & 32'hFFFF_FFFC);
            else if (c == 6) a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
            else             a = 32'h0000_1004;
            e.is_read = 1'($urandom_range(0, 1));
            dev = decode(a);
            if (dev < 0 || is_deaf(a)) begin
                e.err  = 1;
                e.data = 32'h0;
            end else begin
                e.err  = 0;
                e.data = e.is_read ? dev_val(dev, a) : 32'h0;
            end
            if (m == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
            m_addr[m]   = a;
            m_wdata[m]  = $urandom;
            m_strb[m]   = 4'($urandom_range(1, 15));
            m_rd_req[m] = e.is_read;
            m_wr_req[m] = !e.is_read;
            got = 0;
            for (int k = 0; k < 200 && !got; k++) begin
                @(negedge clock);
                if (manager_read_response[m] | manager_write_response[m]) got = 1;
            end
            if (!got) begin
                tests++;
                fails++;
                $display("FAIL mgr%0d_wait: no response within 200 cycles, required a response", m);
            end
            @(posedge clock); #1;
            if (t == n - 1 || $urandom_range(0, 1) == 0) begin
                m_rd_req[m] = 1'b0;
                m_wr_req[m] = 1'b0;
                dly = $urandom_range(0, 2);
                repeat (dly) begin @(posedge clock); #1; end
            end
        end
    endtask

    // Monitor: infers grants from observed pending vectors and checks every device/manager output.
    logic [NM-1:0] prev_pend, mon_resp;
    int   model_last = NM - 1;
    bit   hit_open   = 0;
    int   dur = 0, dresp_cyc = -1, mon_w, mon_r, mon_dev;
    exp_t mon_e;
    bit   mon_have;

    initial begin
        prev_pend = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q0.delete(); exp_q1.delete(); grant_q.delete();
                model_last = NM - 1; hit_open = 0; prev_pend = '0; dur = 0; dresp_cyc = -1;
            end else begin
                if ((device_read_request | device_write_request) != '0) begin
                    if (!hit_open) begin
                        hit_open  = 1;
                        dur       = 0;
                        dresp_cyc = -1;
                        mon_w     = rr_pick(prev_pend, model_last);
                        check("grant_had_pending", 32'(mon_w >= 0), 32'd1);
                        if (mon_w < 0) mon_w = 0;
                        grant_q.push_back(mon_w);
                        mon_dev = decode(m_addr[mon_w]);
                        check("dev_addr", device_rw_address, m_addr[mon_w]);
                        check("dev_rd_req", 32'(device_read_request),
                              (m_rd_req[mon_w] && mon_dev >= 0) ? 32'd1 << mon_dev : 32'd0);
                        check("dev_wr_req", 32'(device_write_request),
                              (!m_rd_req[mon_w] && mon_dev >= 0) ? 32'd1 << mon_dev : 32'd0);
                        if (!m_rd_req[mon_w]) begin
                            check("dev_wdata", device_write_data, m_wdata[mon_w]);
                            check("dev_strobe", 32'(device_write_strobe), 32'(m_strb[mon_w]));
                        end
                    end
                    dur++;
                    if (dresp_cyc < 0 && ((device_read_request & device_read_response) |
                                          (device_write_request & device_write_response)) != '0)
                        dresp_cyc = cyc;
                end
                mon_resp = manager_read_response | manager_write_response;
                if (mon_resp != '0) begin
                    check("resp_onehot", 32'($onehot(mon_resp)), 32'd1);
                    mon_r = mon_resp[0] ? 0 : 1;
                    if (hit_open) mon_w = (grant_q.size() > 0) ? grant_q.pop_front() : -1;
                    else          mon_w = rr_pick(prev_pend, model_last);
                    check("grant_order", 32'(mon_r), 32'(mon_w));
                    mon_have = 0;
                    if (mon_r == 0 && exp_q0.size() > 0) begin mon_e = exp_q0.pop_front(); mon_have = 1; end
                    if (mon_r == 1 && exp_q1.size() > 0) begin mon_e = exp_q1.pop_front(); mon_have = 1; end
                    if (!mon_have) begin
                        check("unexpected_resp", 32'(mon_r), 32'hFFFF_FFFF);
                    end else begin
                        check("resp_is_read", 32'(manager_read_response[mon_r]), 32'(mon_e.is_read));
                        check("resp_error", 32'(manager_access_error[mon_r]), 32'(mon_e.err));
                        check("resp_error_others", 32'(manager_access_error & ~mon_resp), 32'd0);
                        if (mon_e.is_read) check("resp_rdata", manager_read_data, mon_e.data);
                        if (hit_open) begin
                            if (dresp_cyc >= 0) check("resp_latency", 32'(cyc - dresp_cyc), 32'd1);
                            else                check("timeout_len", 32'(dur), 32'(TMO));
                        end
                    end
                    model_last = mon_r;
                    hit_open   = 0;
                end else begin
                    check("idle_rdata", manager_read_data, 32'd0);
                    check("idle_error", 32'(manager_access_error), 32'd0);
                end
                prev_pend = manager_read_request | manager_write_request;
            end
        end
    end

    initial begin
        for (int i = 0; i < NM; i++) begin
            m_addr[i] = '0; m_wdata[i] = '0; m_strb[i] = '0; m_rd_req[i] = 1'b0; m_wr_req[i] = 1'b0;
        end
        for (int i = 0; i < ND; i++) begin
            d_rdata[i] = '0; d_rresp[i] = 1'b0; d_wresp[i] = 1'b0;
        end
        // Overlapping layout first: device 1 sits inside device 0 and must never be selected.
        d_start[0] = 32'h0000_0000; d_size[0] = 32'h0000_2000;
        d_start[1] = 32'h0000_1000; d_size[1] = 32'h0000_1000;
        fork
            run_dev(0);
            run_dev(1);
        join_none

        repeat (4) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_dev_addr", device_rw_address, 32'd0);
        check("rst_dev_wdata", device_write_data, 32'd0);
        check("rst_dev_strobe", 32'(device_write_strobe), 32'd0);
        check("rst_dev_req", 32'({device_read_request, device_write_request}), 32'd0);
        check("rst_mgr_resp", 32'({manager_read_response, manager_write_response}), 32'd0);
        check("rst_mgr_err", 32'(manager_access_error), 32'd0);

        // Reset during ACCESS on a non-answering address: silent abort.
        @(posedge clock); #1;
        m_addr[0] = 32'h0000_0E00; m_rd_req[0] = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("pre_rst_dev_req", 32'(device_read_request), 32'd1);
        @(posedge clock); #1;
        reset = 1'b1; m_rd_req[0] = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("rst_abort_dev_req", 32'(device_read_request), 32'd0);
        check("rst_abort_no_resp", 32'(manager_read_response), 32'd0);
        @(posedge clock); #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Both managers start together so manager 0 must win first after reset.
        fork
            run_mgr(0, 40);
            run_mgr(1, 40);
        join

        d_start[1] = 32'h0001_0000; d_size[1] = 32'h0000_1000;
        repeat (2) @(posedge clock);
        #1;
        fork
            run_mgr(0, 40);
            run_mgr(1, 40);
        join

        repeat (5) @(posedge clock);
        @(negedge clock);
        check("drain_exp_q0", 32'(exp_q0.size()), 32'd0);
        check("drain_exp_q1", 32'(exp_q1.size()), 32'd0);
        check("drain_grant_q", 32'(grant_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
